inst_rom: RTL and testbench

Instruction-memory responder for the fetch stage. It accepts the fetch-enable and instruction-address pair issued by the PC register and returns the addressed 32-bit instruction one cycle later. It carries a boot-time load port through which the test harness or boot loader writes the program image before fetching starts. It also flags misaligned or out-of-range fetches and keeps a fetch counter for debug.

---
 rtl/inst_rom_pkg.sv | 28 ++
 rtl/inst_rom_array.sv | 27 ++
 rtl/inst_rom.sv | 121 ++++++++++++
 tb/tb_inst_rom.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/inst_rom_pkg.sv
// Shared definitions for the instruction-memory responder: bus widths,
// enable levels, state encodings and the fetch-address legality check.
package inst_rom_pkg;

    localparam int INST_ADDR_W       = 32;
    localparam int INST_W            = 32;
    localparam int INST_MEM_NUM_LOG2 = 10;

    typedef logic [INST_ADDR_W-1:0] inst_addr_t;
    typedef logic [INST_W-1:0]      inst_t;

    localparam logic  ENABLE    = 1'b1;
    localparam logic  DISABLE   = 1'b0;
    localparam inst_t ZERO_WORD = 32'h0000_0000;

    typedef enum logic [0:0] {
        ROM_BOOT = 1'b0,
        ROM_RUN  = 1'b1
    } rom_state_e;

    // A fetch is legal when word-aligned and every bit above the word index is zero.
    function automatic logic fetch_addr_ok(input inst_addr_t pc, input int depth_log2);
        inst_addr_t hi_s;
        hi_s = pc >> (depth_log2 + 2);
        return (pc[1:0] == 2'b00) && (hi_s == ZERO_WORD);
    endfunction

endpackage

// File: rtl/inst_rom_array.sv
// Single-port synchronous instruction array: one write, one registered read,
// no reset so it maps onto block RAM and keeps its contents across rst.
module rom_array #(
    parameter int DEPTH_LOG2 = 10,
    parameter int WIDTH      = 32
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic                  re,
    input  logic [DEPTH_LOG2-1:0] addr,
    input  logic [WIDTH-1:0]      wdata,
    output logic [WIDTH-1:0]      rdata
);

    logic [WIDTH-1:0] mem_r [0:(1 << DEPTH_LOG2)-1];

    // Write port and registered read port sharing one address.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[addr] <= wdata;
        end
        if (re) begin
            rdata <= mem_r[addr];
        end
    end

endmodule

// File: rtl/inst_rom.sv
// Instruction-memory responder: boot-time load port, one-cycle fetch path
// with alignment/range checking, and a free-running fetch counter.
module inst_rom
    import inst_rom_pkg::*;
#(
    parameter int DEPTH_LOG2 = INST_MEM_NUM_LOG2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ce,
    input  logic [31:0]           pc,
    output logic [31:0]           inst,
    output logic                  inst_valid,
    output logic                  addr_err,
    input  logic                  load_valid,
    output logic                  load_ready,
    input  logic [DEPTH_LOG2-1:0] load_addr,
    input  logic [31:0]           load_data,
    input  logic                  load_done,
    output logic                  running,
    output logic [31:0]           fetch_cnt
);

    rom_state_e            state_r;
    rom_state_e            state_next_s;
    logic                  accept_s;
    logic                  good_s;
    logic                  we_s;
    logic                  re_s;
    logic [DEPTH_LOG2-1:0] addr_s;
    logic [31:0]           cnt_next_s;
    logic [31:0]           rdata_s;
    logic                  valid_r;
    logic                  err_r;
    logic                  hit_r;
    logic                  load_ready_r;
    logic                  running_r;
    logic [31:0]           fetch_cnt_r;

    // Next-state logic: BOOT leaves on load_done, RUN is left only by reset.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ROM_BOOT: begin
                if (load_done == ENABLE) begin
                    state_next_s = ROM_RUN;
                end else begin
                    state_next_s = ROM_BOOT;
                end
            end
            ROM_RUN:  state_next_s = ROM_RUN;
            default:  state_next_s = ROM_BOOT;
        endcase
    end

    // Fetch acceptance, write strobe and shared array address selection.
    always_comb begin
        accept_s = (state_r == ROM_RUN) && (ce == ENABLE);
        good_s   = fetch_addr_ok(pc, DEPTH_LOG2);
        we_s     = (state_r == ROM_BOOT) && (load_valid == ENABLE) && load_ready_r;
        re_s     = accept_s && good_s;
        addr_s   = pc[DEPTH_LOG2+1:2];
        if (we_s) begin
            addr_s = load_addr;
        end else begin
            addr_s = pc[DEPTH_LOG2+1:2];
        end
    end

    // Counter increment wraps naturally at 32 bits.
    always_comb begin
        cnt_next_s = fetch_cnt_r;
        if (accept_s) begin
            cnt_next_s = fetch_cnt_r + 32'd1;
        end else begin
            cnt_next_s = fetch_cnt_r;
        end
    end

    // State, response flags, handshake outputs and counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ROM_BOOT;
            valid_r      <= DISABLE;
            err_r        <= DISABLE;
            hit_r        <= DISABLE;
            load_ready_r <= DISABLE;
            running_r    <= DISABLE;
            fetch_cnt_r  <= ZERO_WORD;
        end else begin
            state_r      <= state_next_s;
            valid_r      <= accept_s;
            err_r        <= accept_s && !good_s;
            hit_r        <= accept_s && good_s;
            load_ready_r <= (state_next_s == ROM_BOOT);
            running_r    <= (state_next_s == ROM_RUN);
            fetch_cnt_r  <= cnt_next_s;
        end
    end

    rom_array #(
        .DEPTH_LOG2 (DEPTH_LOG2),
        .WIDTH      (INST_W)
    ) u_rom_array (
        .clk   (clk),
        .we    (we_s),
        .re    (re_s),
        .addr  (addr_s),
        .wdata (load_data),
        .rdata (rdata_s)
    );

    // The array read register has no reset, so gate its data with the hit flag.
    assign inst       = hit_r ? rdata_s : ZERO_WORD;
    assign inst_valid = valid_r;
    assign addr_err   = err_r;
    assign load_ready = load_ready_r;
    assign running    = running_r;
    assign fetch_cnt  = fetch_cnt_r;

endmodule

// File: tb/tb_inst_rom.sv
// Directed bench for inst_rom: an abstract boot/run model predicts every
// output each cycle, plus literal checks pinning the model at key points.
module tb_inst_rom;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ce = 1'b0;
    logic [31:0] pc = 32'd0;
    logic [31:0] inst;
    logic        inst_valid;
    logic        addr_err;
    logic        load_valid = 1'b0;
    logic        load_ready;
    logic [9:0]  load_addr = 10'd0;
    logic [31:0] load_data = 32'd0;
    logic        load_done = 1'b0;
    logic        running;
    logic [31:0] fetch_cnt;

    int n_vec = 0;
    int n_err = 0;

    // Model state
    logic [31:0] m_mem [0:1023];
    logic        m_run = 1'b0;
    logic        m_lr = 1'b0;
    logic        m_valid = 1'b0;
    logic        m_err = 1'b0;
    logic [31:0] m_inst = 32'd0;
    logic [31:0] m_cnt = 32'd0;
    logic        bd_req = 1'b0;

    inst_rom #(.DEPTH_LOG2(10)) dut (
        .clk        (clk),
        .rst        (rst),
        .ce         (ce),
        .pc         (pc),
        .inst       (inst),
        .inst_valid (inst_valid),
        .addr_err   (addr_err),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .load_addr  (load_addr),
        .load_data  (load_data),
        .load_done  (load_done),
        .running    (running),
        .fetch_cnt  (fetch_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec = n_vec + 1;
        if (act !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Advance the model by one clock using the inputs held for this cycle.
    task automatic model_step();
        if (rst) begin
            m_run = 1'b0; m_lr = 1'b0; m_valid = 1'b0;
            m_err = 1'b0; m_inst = 32'd0; m_cnt = 32'd0;
        end else begin
            if (!m_run && load_valid && m_lr) m_mem[load_addr] = load_data;
            if (m_run && ce) begin
                m_valid = 1'b1;
                m_cnt   = m_cnt + 32'd1;
                if ((pc % 4 == 0) && (pc < 32'd4096)) begin
                    m_err  = 1'b0;
                    m_inst = m_mem[pc / 4];
                end else begin
                    m_err  = 1'b1;
                    m_inst = 32'd0;
                end
            end else begin
                m_valid = 1'b0; m_err = 1'b0; m_inst = 32'd0;
            end
            if (bd_req) m_cnt = 32'hFFFF_FFFF;
            if (!m_run && load_done) m_run = 1'b1;
            m_lr = !m_run;
        end
    endtask

    // Apply one cycle of stimulus, then compare every output against the model.
    task automatic cyc(input logic c, input logic [31:0] p, input logic lv,
                       input logic [9:0] la, input logic [31:0] ld, input logic dn);
        ce = c; pc = p; load_valid = lv; load_addr = la; load_data = ld; load_done = dn;
        model_step();
        @(negedge clk);
        check("inst",       inst,              m_inst);
        check("inst_valid", 32'(inst_valid),   32'(m_valid));
        check("addr_err",   32'(addr_err),     32'(m_err));
        check("running",    32'(running),      32'(m_run));
        check("load_ready", 32'(load_ready),   32'(m_lr));
        check("fetch_cnt",  fetch_cnt,         m_cnt);
    endtask

    task automatic idle();
        cyc(1'b0, 32'd0, 1'b0, 10'd0, 32'd0, 1'b0);
    endtask

    task automatic fetch(input logic [31:0] p);
        cyc(1'b1, p, 1'b0, 10'd0, 32'd0, 1'b0);
    endtask

    task automatic load(input logic [9:0] a, input logic [31:0] d);
        cyc(1'b0, 32'd0, 1'b1, a, d, 1'b0);
    endtask

    initial begin
        @(negedge clk);
        rst = 1'b1;
        idle();
        idle();
        check("rst_inst_valid", 32'(inst_valid), 32'd0);
        check("rst_running",    32'(running),    32'd0);
        rst = 1'b0;
        idle();
        check("boot_load_ready", 32'(load_ready), 32'd1);

        // Fetch during BOOT is ignored
        fetch(32'd0);
        check("boot_no_valid", 32'(inst_valid), 32'd0);
        check("boot_cnt",      fetch_cnt,       32'd0);

        load(10'd0,    32'h2001_0001);
        load(10'd1,    32'h2002_0002);
        load(10'd2,    32'h2003_0003);
        load(10'd3,    32'h0000_0000);
        load(10'd1023, 32'hCAFE_F00D);
        // Final write and load_done together; the same-cycle ce is not served
        cyc(1'b1, 32'd0, 1'b1, 10'd5, 32'hDEAD_BEEF, 1'b1);
        check("run_after_done",   32'(running),    32'd1);
        check("done_ce_unserved", 32'(inst_valid), 32'd0);
        check("run_load_ready",   32'(load_ready), 32'd0);

        fetch(32'd0);  check("word0", inst, 32'h2001_0001);
        fetch(32'd4);  check("word1", inst, 32'h2002_0002);
        fetch(32'd8);  check("word2", inst, 32'h2003_0003);
        fetch(32'd12); check("word3", inst, 32'h0000_0000);
        check("cnt4", fetch_cnt, 32'd4);

        fetch(32'h0000_0006);
        check("misalign_err", 32'(addr_err), 32'd1);
        check("misalign_inst", inst, 32'd0);
        fetch(32'h0000_1000);
        check("range_err", 32'(addr_err), 32'd1);
        fetch(32'h0000_0FFC);
        check("last_word", inst, 32'hCAFE_F00D);
        check("last_noerr", 32'(addr_err), 32'd0);
        fetch(32'h0000_0014);
        check("boot_write5", inst, 32'hDEAD_BEEF);
        idle();
        check("ce0_invalid", 32'(inst_valid), 32'd0);

        // Load port is ignored in RUN
        load(10'd0, 32'hFFFF_FFFF);
        fetch(32'd0);
        check("run_readonly", inst, 32'h2001_0001);

        // Reset mid-stream drops the in-flight fetch
        fetch(32'd4);
        rst = 1'b1;
        fetch(32'd8);
        check("midrst_valid", 32'(inst_valid), 32'd0);
        check("midrst_cnt",   fetch_cnt,       32'd0);
        check("midrst_run",   32'(running),    32'd0);
        rst = 1'b0;
        fetch(32'd0);
        check("midrst_lr", 32'(load_ready), 32'd1);
        cyc(1'b0, 32'd0, 1'b0, 10'd0, 32'd0, 1'b1);
        fetch(32'd0);
        check("survive_rst", inst, 32'h2001_0001);

        // Counter wrap via backdoor
        force dut.fetch_cnt_r = 32'hFFFF_FFFF;
        bd_req = 1'b1;
        idle();
        check("bd_cnt", fetch_cnt, 32'hFFFF_FFFF);
        release dut.fetch_cnt_r;
        bd_req = 1'b0;
        fetch(32'd4);
        check("cnt_wrap", fetch_cnt, 32'd0);
        check("wrap_inst", inst, 32'h2002_0002);
        idle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
